// File: rtl/data_ram_if.sv
// Data RAM bus between the execute-stage requester and the RAM responder.
// The requester drives the request fields; the responder returns read data, ready and error.
interface data_ram_if;
    logic        data_ram_en;
    logic [31:0] data_ram_addr;
    logic [3:0]  data_ram_w_en;
    logic [31:0] data_ram_w_data;
    logic [31:0] data_ram_r_data;
    logic        data_ram_ready;
    logic        data_ram_err;

    modport master (
        output data_ram_en, data_ram_addr, data_ram_w_en, data_ram_w_data,
        input  data_ram_r_data, data_ram_ready, data_ram_err
    );

    modport slave (
        input  data_ram_en, data_ram_addr, data_ram_w_en, data_ram_w_data,
        output data_ram_r_data, data_ram_ready, data_ram_err
    );
endinterface

// File: rtl/data_ram_resp.sv
// Data RAM responder: byte-writable word array with write-first registered reads,
// a post-reset zeroing sequencer, and error flagging for out-of-range or early accesses.
module data_ram_resp #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    data_ram_if.slave bus
);
    typedef enum logic {S_INIT, S_READY} state_t;

    localparam state_t            RESET_STATE = INIT_ZERO ? S_INIT : S_READY;
    localparam logic [ADDR_W-1:0] CNT_LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] widx;
    logic              in_range;
    logic              ready;
    logic              init_we;
    logic              acc_bad;
    logic              wr_ok;
    logic [31:0]       old_word;
    logic [31:0]       merged;
    logic [31:0]       r_data_p1;
    logic              err_p1;
    logic              unused_addr_lsb;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

    // Byte lanes come from w_en, so the low address bits carry no information.
    assign unused_addr_lsb = ^bus.data_ram_addr[1:0];
    assign widx            = bus.data_ram_addr[ADDR_W+1:2];
    assign in_range        = (bus.data_ram_addr[31:ADDR_W+2] == '0);
    assign old_word        = mem[widx];
    assign merged          = merge_bytes(old_word, bus.data_ram_w_data, bus.data_ram_w_en);

    always_ff @(posedge clk) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (cnt == CNT_LAST) state_nxt = S_READY;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        ready   = (state == S_READY);
        init_we = (state == S_INIT);
        acc_bad = bus.data_ram_en && (!ready || !in_range);
        wr_ok   = bus.data_ram_en && ready && in_range && (bus.data_ram_w_en != 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (reset)        cnt <= '0;
        else if (init_we) cnt <= cnt + ADDR_W'(1);
    end

    // Array is never reset directly; the sequencer owns the write port until READY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_we)    mem[cnt]  <= '0;
            else if (wr_ok) mem[widx] <= merged;
        end
    end

    // ---- stage p1: registered response for the previous cycle's request ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_p1 <= '0;
            err_p1    <= 1'b0;
        end else if (bus.data_ram_en) begin
            if (acc_bad) begin
                r_data_p1 <= '0;
                err_p1    <= 1'b1;
            end else begin
                r_data_p1 <= merged;
                err_p1    <= 1'b0;
            end
        end else begin
            err_p1 <= 1'b0;
        end
    end

    assign bus.data_ram_r_data = r_data_p1;
    assign bus.data_ram_err    = err_p1;
    assign bus.data_ram_ready  = ready;
endmodule

// File: tb/tb_data_ram_resp.sv
// Bench for data_ram_resp: directed table, multi-cycle corner sequences and
// randomized traffic checked against a word-array reference model.
module tb_data_ram_resp;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_ram_if bus();

    data_ram_resp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] ref_mem [DEPTH];
    int          since_reset;
    logic [31:0] exp_r;
    logic        exp_err;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [31:0] exp_r;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // One request cycle: model predicts the response from the RAM's rules, then compares.
    task automatic cycle(input string tag, input logic en, input logic [31:0] addr,
                         input logic [3:0] we, input logic [31:0] wd);
        logic model_ready;
        int   idx;
        bus.data_ram_en     = en;
        bus.data_ram_addr   = addr;
        bus.data_ram_w_en   = we;
        bus.data_ram_w_data = wd;
        model_ready = (since_reset >= DEPTH);
        chk({tag, " ready"}, 32'(bus.data_ram_ready), 32'(model_ready));
        if (en) begin
            if (!model_ready || addr >= 32'(4 * DEPTH)) begin
                exp_r   = 32'h0;
                exp_err = 1'b1;
            end else begin
                idx = int'(addr / 4);
                for (int b = 0; b < 4; b++)
                    if (we[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                exp_r   = ref_mem[idx];
                exp_err = 1'b0;
            end
        end else begin
            exp_err = 1'b0;
        end
        @(posedge clk);
        #1;
        since_reset++;
        chk({tag, " r_data"}, bus.data_ram_r_data, exp_r);
        chk({tag, " err"}, 32'(bus.data_ram_err), 32'(exp_err));
    endtask

    task automatic do_reset();
        reset               = 1'b1;
        bus.data_ram_en     = 1'b0;
        bus.data_ram_addr   = 32'h0;
        bus.data_ram_w_en   = 4'h0;
        bus.data_ram_w_data = 32'h0;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        since_reset = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        exp_r   = 32'h0;
        exp_err = 1'b0;
        chk("reset r_data", bus.data_ram_r_data, 32'h0);
        chk("reset err", 32'(bus.data_ram_err), 32'h0);
        chk("reset ready", 32'(bus.data_ram_ready), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h08, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 32'h08, 4'h2, 32'h0000AA00, 32'hDEADAAEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h08, 4'h0, 32'h00000000, 32'hDEADAAEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h04, 4'hF, 32'h11223344, 32'h11223344, 1'b0};
        vecs[4]  = '{1'b1, 32'h04, 4'h8, 32'h99000000, 32'h99223344, 1'b0};
        vecs[5]  = '{1'b1, 32'h04, 4'h0, 32'h00000000, 32'h99223344, 1'b0};
        vecs[6]  = '{1'b1, 32'h40, 4'hF, 32'h12345678, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 32'h00, 4'h0, 32'h00000000, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 32'h00, 4'h0, 32'h00000000, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 32'h08, 4'h0, 32'h00000000, 32'hDEADAAEF, 1'b0};
        vecs[10] = '{1'b0, 32'h00, 4'h0, 32'h00000000, 32'hDEADAAEF, 1'b0};
        vecs[11] = '{1'b0, 32'h08, 4'h0, 32'h00000000, 32'hDEADAAEF, 1'b0};
        vecs[12] = '{1'b0, 32'h00, 4'h0, 32'h00000000, 32'hDEADAAEF, 1'b0};
        vecs[13] = '{1'b1, 32'h3C, 4'h0, 32'h00000000, 32'h00000000, 1'b0};
        vecs[14] = '{1'b0, 32'h3C, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[15] = '{1'b1, 32'h3C, 4'h0, 32'h00000000, 32'h00000000, 1'b0};
        vecs[16] = '{1'b1, 32'h44, 4'h0, 32'h00000000, 32'h00000000, 1'b1};

        // Init window: ready low for DEPTH cycles, then every word reads zero.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle($sformatf("init%0d", i), 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle($sformatf("zero%0d", i), 1'b1, 32'(4 * i), 4'h0, 32'h0);
            chk($sformatf("zero%0d const", i), bus.data_ram_r_data, 32'h0);
        end

        for (int i = 0; i < 17; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].we, vecs[i].wd);
            chk($sformatf("vec%0d tbl r_data", i), bus.data_ram_r_data, vecs[i].exp_r);
            chk($sformatf("vec%0d tbl err", i), 32'(bus.data_ram_err), 32'(vecs[i].exp_err));
        end

        // Reset in the middle of init must restart the full clearing pass.
        cycle("pre wr2", 1'b1, 32'h08, 4'hF, 32'hFFFFFFFF);
        chk("pre wr2 const", bus.data_ram_r_data, 32'hFFFFFFFF);
        do_reset();
        for (int i = 0; i < 7; i++) cycle($sformatf("rinit%0d", i), 1'b0, 32'h0, 4'h0, 32'h0);
        do_reset();
        cycle("early wr", 1'b1, 32'h08, 4'hF, 32'hAAAA5555);
        chk("early wr err const", 32'(bus.data_ram_err), 32'h1);
        chk("early wr r_data const", bus.data_ram_r_data, 32'h0);
        for (int i = 1; i < DEPTH; i++) cycle($sformatf("re_init%0d", i), 1'b0, 32'h0, 4'h0, 32'h0);
        cycle("post rd2", 1'b1, 32'h08, 4'h0, 32'h0);
        chk("post rd2 const", bus.data_ram_r_data, 32'h0);

        // Randomized traffic, with one reset landing partway through.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            if (i == 200) do_reset();
            a = ($urandom % 16 == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 15));
            cycle($sformatf("rnd%0d", i), ($urandom % 4) != 0, a, 4'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
